// File: rtl/video_sync_gen_if.sv
// video_sync_gen_if: timing stream produced by video_sync_gen.
//   master : the timing generator drives every signal.
//   slave  : downstream video stages (scanline, scaler, output bridge) observe.
// Signals:
//   oHCNT/oVCNT : current pixel coordinates (10 bit)
//   oHS/oVS     : sync levels, polarity set by the generator parameters
//   oDE         : active-area data enable
//   oCE         : pixel clock enable, one iPCLK cycle wide
//   oSOF        : start of frame, high with oCE at pixel (0,0)
interface video_sync_gen_if;
  logic [9:0] oHCNT;
  logic [9:0] oVCNT;
  logic       oHS;
  logic       oVS;
  logic       oDE;
  logic       oCE;
  logic       oSOF;

  modport master (output oHCNT, oVCNT, oHS, oVS, oDE, oCE, oSOF);
  modport slave  (input  oHCNT, oVCNT, oHS, oVS, oDE, oCE, oSOF);
endinterface

// File: rtl/video_sync_gen.sv
// video_sync_gen: parameterised video timing generator.
//   Divides iPCLK by CE_DIV into a pixel enable, walks an H_TOTAL x V_TOTAL
//   raster and emits a registered HS/VS/DE/CE/SOF stream with coordinates.
// Ports:
//   iPCLK : pixel clock, the only clock
//   iRST  : synchronous active-high reset
//   vid   : timing stream (video_sync_gen_if.master)
module video_sync_gen #(
  parameter int H_ACTIVE = 160,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 16,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 160,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 28,
  parameter int CE_DIV   = 4,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic              iPCLK,
  input  logic              iRST,
  video_sync_gen_if.master  vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Bad timing must stop elaboration; the counters never saturate.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CE_DIV < 1 || CE_DIV > 16) begin : gBadParam
    $error("video_sync_gen: timing parameters out of range");
  end

  localparam logic [3:0] CE_LAST  = 4'(CE_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0] ceCnt;
  logic [9:0] hcnt, vcnt;
  logic       tick;

  logic [9:0] hcntQ, vcntQ;
  logic       hsQ, vsQ, deQ, ceQ, sofQ;

  // Decode of the pre-increment position, loaded into the output register on tick.
  logic deD, hsActD, vsActD, sofD;

  // CE_DIV=1 makes CE_LAST zero, so tick is then permanently true.
  assign tick = (ceCnt == CE_LAST);

  always_comb begin
    deD    = (hcnt < H_ACT) && (vcnt < V_ACT);
    hsActD = (hcnt >= HS_BEG) && (hcnt <= HS_END);
    // VS depends on vcnt only, so its edges fall on line starts (hcnt==0).
    vsActD = (vcnt >= VS_BEG) && (vcnt <= VS_END);
    sofD   = (hcnt == 10'd0) && (vcnt == 10'd0);
  end

  always_ff @(posedge iPCLK) begin
    if (iRST) begin
      ceCnt <= 4'd0;
      hcnt  <= 10'd0;
      vcnt  <= 10'd0;
      hcntQ <= 10'd0;
      vcntQ <= 10'd0;
      hsQ   <= ~HS_POL;
      vsQ   <= ~VS_POL;
      deQ   <= 1'b0;
      ceQ   <= 1'b0;
      sofQ  <= 1'b0;
    end else begin
      ceCnt <= tick ? 4'd0 : ceCnt + 4'd1;
      ceQ   <= tick;
      if (tick) begin
        hcntQ <= hcnt;
        vcntQ <= vcnt;
        deQ   <= deD;
        hsQ   <= hsActD ? HS_POL : ~HS_POL;
        vsQ   <= vsActD ? VS_POL : ~VS_POL;
        sofQ  <= sofD;
        if (hcnt == H_LAST) begin
          hcnt <= 10'd0;
          vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  assign vid.oHCNT = hcntQ;
  assign vid.oVCNT = vcntQ;
  assign vid.oHS   = hsQ;
  assign vid.oVS   = vsQ;
  assign vid.oDE   = deQ;
  assign vid.oCE   = ceQ;
  assign vid.oSOF  = sofQ;
endmodule

// File: tb/tb_video_sync_gen.sv
// tb_video_sync_gen: three generator instances share one clock/reset.
//   u0 : default raster, CE_DIV=1, active-low syncs
//   u1 : all defaults
//   u2 : small raster, CE_DIV=3, mixed polarity (many frame wraps)
// Reference: output at a cycle is derived from the number of cycles since
// reset release, converted to a pixel index and decoded arithmetically.
module tb_video_sync_gen;
  logic iPCLK = 1'b0;
  logic iRST  = 1'b1;
  always #5 iPCLK = ~iPCLK;

  video_sync_gen_if v0 ();
  video_sync_gen_if v1 ();
  video_sync_gen_if v2 ();

  video_sync_gen #(.CE_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0)) u0 (
    .iPCLK(iPCLK), .iRST(iRST), .vid(v0));
  video_sync_gen u1 (
    .iPCLK(iPCLK), .iRST(iRST), .vid(v1));
  video_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
                   .CE_DIV(3), .HS_POL(1'b1), .VS_POL(1'b0)) u2 (
    .iPCLK(iPCLK), .iRST(iRST), .vid(v2));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {hcnt, vcnt, hs, vs, de, ce, sof} t cycles after reset release.
  function automatic logic [24:0] refOut(int t, int cediv,
      int ha, int hfp, int hsw, int hbp, int va, int vfp, int vsw, int vbp,
      bit hpol, bit vpol);
    int ht, vt, n, p, h, v;
    bit inH, inV;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    n  = t / cediv;                 // pixels emitted so far
    if (n == 0) return {10'd0, 10'd0, ~hpol, ~vpol, 3'b000};
    p = (n - 1) % (ht * vt);
    h = p % ht;
    v = p / ht;
    inH = (h >= ha + hfp) && (h < ha + hfp + hsw);
    inV = (v >= va + vfp) && (v < va + vfp + vsw);
    return {10'(h), 10'(v), inH ? hpol : ~hpol, inV ? vpol : ~vpol,
            (h < ha) && (v < va), (t % cediv) == 0, (h == 0) && (v == 0)};
  endfunction

  int  tRel  = 0;
  bit  armed = 1'b0;
  bit  done  = 1'b0;

  always @(posedge iPCLK) begin
    if (iRST) begin
      tRel  <= 0;
      armed <= 1'b1;
    end else begin
      tRel  <= tRel + 1;
    end
  end

  always @(negedge iPCLK) begin
    if (armed && !done) begin
      chk("u0", {v0.oHCNT, v0.oVCNT, v0.oHS, v0.oVS, v0.oDE, v0.oCE, v0.oSOF},
          refOut(tRel, 1, 160, 16, 16, 48, 160, 8, 4, 28, 1'b0, 1'b0));
      chk("u1", {v1.oHCNT, v1.oVCNT, v1.oHS, v1.oVS, v1.oDE, v1.oCE, v1.oSOF},
          refOut(tRel, 4, 160, 16, 16, 48, 160, 8, 4, 28, 1'b1, 1'b1));
      chk("u2", {v2.oHCNT, v2.oVCNT, v2.oHS, v2.oVS, v2.oDE, v2.oCE, v2.oSOF},
          refOut(tRel, 3, 8, 2, 3, 4, 6, 1, 2, 3, 1'b1, 1'b0));
    end
  end

  // u2 frame length in oCE pulses, measured between SOF strobes without reset.
  int  ceSinceSof = 0;
  int  frameLen   = -1;
  bit  sofSeen    = 1'b0;
  always @(negedge iPCLK) begin
    if (iRST) begin
      sofSeen    <= 1'b0;
      ceSinceSof <= 0;
    end else if (v2.oCE) begin
      if (v2.oSOF) begin
        if (sofSeen) frameLen <= ceSinceSof;
        sofSeen    <= 1'b1;
        ceSinceSof <= 1;
      end else begin
        ceSinceSof <= ceSinceSof + 1;
      end
    end
  end

  initial begin
    bit found;
    // Reset held 5 cycles; outputs checked every cycle by the model.
    repeat (5) @(posedge iPCLK);
    #1 iRST = 1'b0;

    // Run u0 to (100,170), inside its VS pulse, then reset for one cycle.
    found = 1'b0;
    for (int i = 0; i < 50000; i++) begin
      @(negedge iPCLK);
      if (v0.oHCNT == 10'd100 && v0.oVCNT == 10'd170) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_wait", 25'(found), 25'd1);
    chk("vs_in_pulse", 25'(v0.oVS), 25'd0);
    iRST = 1'b1;
    @(negedge iPCLK);
    chk("vs_after_rst", 25'(v0.oVS), 25'd1);
    @(posedge iPCLK);
    #1 iRST = 1'b0;

    // Random run lengths with random reset bursts.
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(800, 50)) @(posedge iPCLK);
      #1 iRST = 1'b1;
      repeat ($urandom_range(3, 1)) @(posedge iPCLK);
      #1 iRST = 1'b0;
    end
    // Long enough for several complete u2 frames.
    repeat (3000) @(posedge iPCLK);
    @(negedge iPCLK);
    chk("u2_frame_len", 25'(frameLen), 25'd204);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
